// File: rtl/alarm_annunciator.sv
// Siren and status-LED driver for the car alarm controller. It produces arm/disarm
// confirmation chirps and a pulsed alarm siren whose total on-time is capped.
module alarm_annunciator #(
  parameter int CHIRP_ON   = 4,
  parameter int CHIRP_OFF  = 4,
  parameter int SIREN_ON   = 8,
  parameter int SIREN_OFF  = 8,
  parameter int SIREN_MAX  = 64,
  parameter int LED_PERIOD = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic alarme,
  input  logic armado,
  input  logic armar_evt,
  input  logic desarmar_evt,
  output logic siren,
  output logic led,
  output logic busy
);

  localparam int CHIRP_MAXP = (CHIRP_ON > CHIRP_OFF) ? CHIRP_ON : CHIRP_OFF;
  localparam int SIREN_MAXP = (SIREN_ON > SIREN_OFF) ? SIREN_ON : SIREN_OFF;
  localparam int PH_MAXP    = (CHIRP_MAXP > SIREN_MAXP) ? CHIRP_MAXP : SIREN_MAXP;
  localparam int PW = $clog2(PH_MAXP) + 1;
  localparam int MW = $clog2(SIREN_MAX) + 1;
  localparam int LW = $clog2(LED_PERIOD) + 1;
  localparam int CW = $clog2(2) + 1;

  localparam logic [PW-1:0] C_ON_W   = PW'(CHIRP_ON);
  localparam logic [PW-1:0] C_OFF_W  = PW'(CHIRP_OFF);
  localparam logic [PW-1:0] S_ON_W   = PW'(SIREN_ON);
  localparam logic [PW-1:0] S_OFF_W  = PW'(SIREN_OFF);
  localparam logic [MW-1:0] S_MAX_W  = MW'(SIREN_MAX);
  localparam logic [LW-1:0] LED_LAST = LW'(LED_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHIRP_HI,
    CHIRP_LO,
    SIREN_HI,
    SIREN_LO,
    SILENCED
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] ph, ph_n, ph_inc;
  logic [MW-1:0] mx, mx_n, mx_inc;
  logic [CW-1:0] cl, cl_n;
  logic [LW-1:0] lc, lc_n;

  always_comb begin
    ph_inc  = (ph == '1) ? ph : ph + 1'b1;
    mx_inc  = (mx == '1) ? mx : mx + 1'b1;
    state_n = state;
    ph_n    = ph;
    mx_n    = mx;
    cl_n    = cl;

    if (alarme) begin
      case (state)
        SIREN_HI, SIREN_LO: begin
          mx_n = mx_inc;
          // The total-time cap wins over the on/off phase change.
          if (mx_inc == S_MAX_W) begin
            state_n = SILENCED;
            ph_n    = '0;
          end else if (state == SIREN_HI && ph_inc == S_ON_W) begin
            state_n = SIREN_LO;
            ph_n    = '0;
          end else if (state == SIREN_LO && ph_inc == S_OFF_W) begin
            state_n = SIREN_HI;
            ph_n    = '0;
          end else begin
            ph_n = ph_inc;
          end
        end
        SILENCED: state_n = SILENCED;
        default: begin
          state_n = SIREN_HI;
          ph_n    = '0;
          mx_n    = '0;
          cl_n    = '0;
        end
      endcase
    end else if (state == SIREN_HI || state == SIREN_LO || state == SILENCED) begin
      state_n = IDLE;
      ph_n    = '0;
      mx_n    = '0;
    end else if (desarmar_evt) begin
      state_n = CHIRP_HI;
      ph_n    = '0;
      cl_n    = CW'(2);
    end else if (armar_evt) begin
      state_n = CHIRP_HI;
      ph_n    = '0;
      cl_n    = CW'(1);
    end else begin
      case (state)
        CHIRP_HI: begin
          if (ph_inc == C_ON_W) begin
            state_n = CHIRP_LO;
            ph_n    = '0;
          end else begin
            ph_n = ph_inc;
          end
        end
        CHIRP_LO: begin
          if (ph_inc == C_OFF_W) begin
            ph_n    = '0;
            cl_n    = (cl == '0) ? cl : cl - 1'b1;
            state_n = (cl_n != '0) ? CHIRP_HI : IDLE;
          end else begin
            ph_n = ph_inc;
          end
        end
        default: state_n = state;
      endcase
    end

    if (!armado || lc == LED_LAST) lc_n = '0;
    else                           lc_n = lc + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ph    <= '0;
      mx    <= '0;
      cl    <= '0;
      lc    <= '0;
      siren <= 1'b0;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ph    <= ph_n;
      mx    <= mx_n;
      cl    <= cl_n;
      lc    <= lc_n;
      siren <= (state_n == CHIRP_HI) || (state_n == SIREN_HI);
      busy  <= (state_n != IDLE);
      if (state_n == SIREN_HI)      led <= 1'b1;
      else if (state_n == SIREN_LO) led <= 1'b0;
      else                          led <= armado && (lc == LED_LAST);
    end
  end

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed and randomized bench for alarm_annunciator against a pattern-queue /
// elapsed-time reference model.
module tb_alarm_annunciator;

  localparam int CHIRP_ON   = 4;
  localparam int CHIRP_OFF  = 4;
  localparam int SIREN_ON   = 8;
  localparam int SIREN_OFF  = 8;
  localparam int SIREN_MAX  = 64;
  localparam int LED_PERIOD = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic alarme = 1'b0, armado = 1'b0, armar_evt = 1'b0, desarmar_evt = 1'b0;
  logic siren, led, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  bit   in_alarm = 1'b0;
  int   t = 0;
  int   n = 0;
  bit   q[$];
  logic es, el, eb;

  alarm_annunciator #(
    .CHIRP_ON(CHIRP_ON), .CHIRP_OFF(CHIRP_OFF), .SIREN_ON(SIREN_ON),
    .SIREN_OFF(SIREN_OFF), .SIREN_MAX(SIREN_MAX), .LED_PERIOD(LED_PERIOD)
  ) dut (
    .clock(clock), .reset(reset), .alarme(alarme), .armado(armado),
    .armar_evt(armar_evt), .desarmar_evt(desarmar_evt),
    .siren(siren), .led(led), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_alarm = 1'b0;
    t = 0;
    n = 0;
    q.delete();
  endtask

  task automatic load(input int c);
    q.delete();
    repeat (c) begin
      repeat (CHIRP_ON)  q.push_back(1'b1);
      repeat (CHIRP_OFF) q.push_back(1'b0);
    end
  endtask

  task automatic model_edge(input logic a, input logic am, input logic ar, input logic ds);
    bit active;
    if (am) n++; else n = 0;
    if (a) begin
      if (!in_alarm) begin
        in_alarm = 1'b1;
        t = 0;
        q.delete();
      end else if (t < SIREN_MAX) begin
        t++;
      end
    end else if (in_alarm) begin
      in_alarm = 1'b0;
      q.delete();
    end else if (ds) begin
      load(2);
    end else if (ar) begin
      load(1);
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end

    if (in_alarm) begin
      active = (t < SIREN_MAX);
      es = active && ((t % (SIREN_ON + SIREN_OFF)) < SIREN_ON);
      eb = 1'b1;
      el = active ? es : (am && (n % LED_PERIOD == 0));
    end else begin
      es = (q.size() > 0) ? q[0] : 1'b0;
      eb = (q.size() > 0);
      el = am && (n % LED_PERIOD == 0);
    end
  endtask

  task automatic step(input logic a, input logic am, input logic ar, input logic ds);
    alarme = a; armado = am; armar_evt = ar; desarmar_evt = ds;
    @(posedge clock);
    model_edge(a, am, ar, ds);
    #1;
    chk("siren", siren, es);
    chk("led", led, el);
    chk("busy", busy, eb);
    armar_evt = 1'b0;
    desarmar_evt = 1'b0;
  endtask

  initial begin
    int highs;
    logic a_lvl, am_lvl;

    // Reset state
    #12;
    chk("rst_siren", siren, 1'b0);
    chk("rst_led", led, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    model_reset();

    // Arm chirp: 4 high, 4 low, busy for 8
    step(0, 0, 1, 0);
    repeat (10) step(0, 0, 0, 0);

    // Disarm chirp and simultaneous arm+disarm: two chirps
    step(0, 0, 0, 1);
    repeat (18) step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    repeat (18) step(0, 0, 0, 0);

    // Restart of a chirp by a new event mid-pattern
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (18) step(0, 0, 0, 0);

    // Alarm preempts a chirp
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (40) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Siren cap, release, fresh budget
    highs = 0;
    repeat (100) begin
      step(1, 0, 0, 0);
      if (siren === 1'b1) highs++;
    end
    chk_int("cap_high_cycles", highs, 4 * SIREN_ON);
    chk("silenced_busy", busy, 1'b1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    highs = 0;
    repeat (20) begin
      step(1, 0, 0, 0);
      if (siren === 1'b1) highs++;
    end
    chk_int("fresh_budget_high", highs, 12);
    repeat (2) step(0, 0, 0, 0);

    // Armed blink, disarm, re-arm
    repeat (40) step(0, 1, 0, 0);
    repeat (20) step(0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);

    // Async reset mid-siren
    repeat (20) step(1, 1, 0, 0);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_siren", siren, 1'b0);
    chk("async_rst_led", led, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    alarme = 1'b0;
    armado = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Randomized traffic
    a_lvl = 1'b0;
    am_lvl = 1'b0;
    repeat (800) begin
      if ($urandom_range(0, 39) == 0) a_lvl = ~a_lvl;
      if ($urandom_range(0, 29) == 0) am_lvl = ~am_lvl;
      step(a_lvl, am_lvl, ($urandom_range(0, 11) == 0), ($urandom_range(0, 13) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_annunciator.md
Name: alarm_annunciator

Overview:
- Output-side counterpart of the car alarm controller.
- Consumes the controller's alarm level and its arm/disarm pulses, and drives the physical siren and status LED.
- Produces confirmation chirps: 1 chirp on arm, 2 chirps on disarm.
- Produces a pulsed siren while the alarm is active, with a hard cap on total siren time.

Parameters:
- CHIRP_ON, 4, cycles siren is high per chirp
- CHIRP_OFF, 4, cycles siren is low after each chirp
- SIREN_ON, 8, cycles siren is high per alarm pulse
- SIREN_OFF, 8, cycles siren is low per alarm pulse
- SIREN_MAX, 64, total alarm cycles (on+off) before forced silence
- LED_PERIOD, 16, armed-blink period in cycles; LED high for 1 cycle per period

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- alarme  input  1  alarm active level from controller
- armado  input  1  level, 1 while controller is in the armed state
- armar_evt  input  1  one-cycle pulse, system armed
- desarmar_evt  input  1  one-cycle pulse, system disarmed
- siren  output  1  siren drive, registered
- led  output  1  status LED, registered
- busy  output  1  1 whenever state is not IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; all counters=0; siren=0; led=0; busy=0.
- States: IDLE, CHIRP_HI, CHIRP_LO, SIREN_HI, SIREN_LO, SILENCED.
- siren=1 exactly when state is CHIRP_HI or SIREN_HI. Outputs are decoded from the registered state, so they have no combinational path from inputs.
- Inputs are sampled on every rising edge. Priority per edge: alarme, then desarmar_evt, then armar_evt.
- alarme=1 in IDLE, CHIRP_HI or CHIRP_LO:
  - Next state is SIREN_HI.
  - Any chirp in progress is aborted.
  - Phase counter and max counter are cleared.
- SIREN_HI lasts SIREN_ON cycles, then SIREN_LO for SIREN_OFF cycles, then back to SIREN_HI.
- Max counter:
  - Increments every cycle spent in SIREN_HI or SIREN_LO.
  - When it reaches SIREN_MAX, the next state is SILENCED with siren=0.
  - This check takes priority over the phase transition.
- alarme=0 in SIREN_HI, SIREN_LO or SILENCED: next state is IDLE and siren=0 on the following cycle. Events arriving on the same edge are dropped.
- SILENCED holds, ignoring all events, until alarme=0. A re-assertion of alarme after IDLE starts a fresh SIREN_MAX budget.
- Chirp start (only when alarme=0):
  - desarmar_evt loads chirps_left=2; otherwise armar_evt loads chirps_left=1.
  - Next state is CHIRP_HI and the phase counter is cleared.
  - If both events arrive on the same edge, disarm wins.
- Chirp sequencing:
  - CHIRP_HI for CHIRP_ON cycles, then CHIRP_LO for CHIRP_OFF cycles.
  - At the end of CHIRP_LO, chirps_left is decremented. If the result is nonzero, go to CHIRP_HI; otherwise go to IDLE.
- A new event during CHIRP_HI or CHIRP_LO restarts the pattern from CHIRP_HI with the new count.
- Timing: an event sampled at edge k makes siren=1 during cycles k+1 .. k+CHIRP_ON.
  - Arm total busy time = CHIRP_ON+CHIRP_OFF = 8 cycles.
  - Disarm total busy time = 16 cycles.
- LED:
  - In SIREN_HI or SIREN_LO, led follows siren.
  - Otherwise, when armado=1, a free-running LED_PERIOD counter (cleared while armado=0) drives led=1 for one cycle when the counter equals LED_PERIOD-1.
  - Otherwise led=0.
- Counter widths: each counter is sized by $clog2 of its parameter +1. Counters saturate and never wrap.
- Parameters below 1 are illegal.

Test Plan:
- Reset mid-siren: alarme=1 for 20 cycles, then reset=0 asynchronously -> siren, led and busy drop to 0 immediately without a clock edge; after release with alarme=0, state is IDLE.
- Arm chirp: one armar_evt pulse -> siren high for 4 cycles, low for 4, busy=1 for 8 cycles, then busy=0.
- Disarm chirp: one desarmar_evt pulse -> siren pattern 1111000011110000, then idle. With armar_evt and desarmar_evt pulsed together -> same 2-chirp pattern.
- Alarm preempts chirp: armar_evt, then alarme=1 two cycles later -> chirp aborted, siren 8 high / 8 low repeating.
- Siren cap: alarme held 100 cycles -> exactly 4 on/off pulses (64 cycles), then siren=0 and busy=1 in SILENCED. alarme=0 -> IDLE next cycle. alarme=1 again -> siren restarts with a fresh 64-cycle budget.
- Armed blink: armado=1 with no alarm -> led=1 for one cycle every 16 cycles. armado=0 -> led stays 0. Restarting armado=1 -> first blink after 16 cycles.
